// File: rtl/dcache_port_arbiter.sv
// Two-requester front end for the single data-cache port. The ROB store-commit
// port and the load/store-buffer load port are arbitrated round-robin. The
// winner is captured into local registers that drive the cache until dc_resp,
// and the cache response is routed back to whichever port owns the transaction.
// A flush squashes the load response but lets the cache access finish.
module dcache_port_arbiter #(
  parameter int XLEN        = 32,
  parameter bit STORE_FIRST = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            st_write,
  input  logic [XLEN-1:0] st_address,
  input  logic [XLEN-1:0] st_wdata,
  input  logic [3:0]      st_byte_enable,
  output logic            st_resp,
  input  logic            ld_read,
  input  logic [XLEN-1:0] ld_address,
  output logic [XLEN-1:0] ld_rdata,
  output logic            ld_resp,
  output logic            dc_read,
  output logic            dc_write,
  output logic [XLEN-1:0] dc_address,
  output logic [XLEN-1:0] dc_wdata,
  output logic [3:0]      dc_byte_enable,
  input  logic [XLEN-1:0] dc_rdata,
  input  logic            dc_resp
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    STORE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic            pri_store_q, pri_store_d;
  logic            drop_q, drop_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [3:0]      be_q, be_d;
  logic            st_elig, ld_elig, grant_st, grant_ld;

  // Control registers: FSM state, round-robin priority and load squash flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      pri_store_q <= STORE_FIRST;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pri_store_q <= pri_store_d;
      drop_q      <= drop_d;
    end
  end

  // Captured request; outputs are gated by state, so these need no reset.
  always_ff @(posedge clk) begin
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    be_q    <= be_d;
  end

  // Round-robin arbitration, only meaningful while idle; flush blocks loads.
  always_comb begin
    st_elig  = st_write;
    ld_elig  = ld_read & ~flush;
    grant_st = (state_q == IDLE) & st_elig & (~ld_elig | pri_store_q);
    grant_ld = (state_q == IDLE) & ld_elig & ~grant_st;
  end

  // Next-state logic: grant from IDLE, finish on dc_resp, remember a flush in LOAD.
  always_comb begin
    state_d     = state_q;
    pri_store_d = pri_store_q;
    drop_d      = drop_q;
    unique case (state_q)
      IDLE: begin
        drop_d = 1'b0;
        if (grant_st) begin
          state_d     = STORE;
          pri_store_d = 1'b0;
        end else if (grant_ld) begin
          state_d     = LOAD;
          pri_store_d = 1'b1;
        end
      end
      LOAD: begin
        if (dc_resp) begin
          state_d = IDLE;
          drop_d  = 1'b0;
        end else if (flush) begin
          drop_d = 1'b1;
        end
      end
      STORE: begin
        if (dc_resp) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Capture the granted request; loads are word-aligned and read the full word.
  always_comb begin
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    if (grant_st) begin
      addr_d  = st_address;
      wdata_d = st_wdata;
      be_d    = st_byte_enable;
    end else if (grant_ld) begin
      addr_d  = {ld_address[XLEN-1:2], 2'b00};
      wdata_d = '0;
      be_d    = 4'b1111;
    end
  end

  // Outputs: drive the cache from the captured copy and route dc_resp to the owner.
  always_comb begin
    dc_read        = 1'b0;
    dc_write       = 1'b0;
    dc_address     = '0;
    dc_wdata       = '0;
    dc_byte_enable = 4'b0000;
    ld_resp        = 1'b0;
    ld_rdata       = '0;
    st_resp        = 1'b0;
    if (!rst) begin
      unique case (state_q)
        LOAD: begin
          dc_read        = 1'b1;
          dc_address     = addr_q;
          dc_wdata       = wdata_q;
          dc_byte_enable = be_q;
          if (dc_resp & ~drop_q & ~flush) begin
            ld_resp  = 1'b1;
            ld_rdata = dc_rdata;
          end
        end
        STORE: begin
          dc_write       = 1'b1;
          dc_address     = addr_q;
          dc_wdata       = wdata_q;
          dc_byte_enable = be_q;
          st_resp        = dc_resp;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Bench for dcache_port_arbiter: directed vector table, hand-written corner
// sequences, and randomized traffic checked each cycle against a
// transaction-level model of the arbiter.
module tb_dcache_port_arbiter;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            flush = 1'b0;
  logic            st_write = 1'b0;
  logic [XLEN-1:0] st_address = '0;
  logic [XLEN-1:0] st_wdata = '0;
  logic [3:0]      st_byte_enable = 4'h0;
  logic            st_resp;
  logic            ld_read = 1'b0;
  logic [XLEN-1:0] ld_address = '0;
  logic [XLEN-1:0] ld_rdata;
  logic            ld_resp;
  logic            dc_read, dc_write;
  logic [XLEN-1:0] dc_address, dc_wdata;
  logic [3:0]      dc_byte_enable;
  logic [XLEN-1:0] dc_rdata = '0;
  logic            dc_resp = 1'b0;

  always #5 clk = ~clk;

  dcache_port_arbiter #(.XLEN(XLEN), .STORE_FIRST(1'b1)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .st_write(st_write), .st_address(st_address), .st_wdata(st_wdata),
    .st_byte_enable(st_byte_enable), .st_resp(st_resp),
    .ld_read(ld_read), .ld_address(ld_address), .ld_rdata(ld_rdata), .ld_resp(ld_resp),
    .dc_read(dc_read), .dc_write(dc_write), .dc_address(dc_address), .dc_wdata(dc_wdata),
    .dc_byte_enable(dc_byte_enable), .dc_rdata(dc_rdata), .dc_resp(dc_resp)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Cache model: answers an active access after a configurable number of cycles.
  bit          rand_mode = 1'b0;
  int          delay_cfg = 0;
  logic [31:0] fixed_rdata = '0;
  int          late_req = 0;
  int          late_ack = 0;
  int          cnt = 0;
  int          cur_delay = 0;

  always @(posedge clk) begin
    #2;
    if (late_req != late_ack) begin
      late_ack = late_req;
      dc_resp  = 1'b1;
      dc_rdata = $urandom;
    end else if (dc_resp) begin
      dc_resp  = 1'b0;
      cnt      = 0;
      dc_rdata = $urandom;
    end else if (dc_read || dc_write) begin
      if (cnt == 0) cur_delay = rand_mode ? int'($urandom_range(0, 3)) : delay_cfg;
      if (cnt >= cur_delay) begin
        dc_resp  = 1'b1;
        dc_rdata = rand_mode ? $urandom : fixed_rdata;
      end else begin
        cnt++;
        dc_rdata = $urandom;
      end
    end else begin
      cnt      = 0;
      dc_rdata = $urandom;
    end
  end

  // Reference model: owner of the cache port (0 none, 1 load, 2 store).
  int          m_busy = 0;
  logic [31:0] m_addr = '0, m_wdata = '0;
  logic [3:0]  m_be = 4'h0;
  bit          m_squash = 1'b0;
  bit          m_turn_st = 1'b1;

  task automatic cyc_start();
    bit st_ok, ld_ok;
    @(posedge clk);
    if (rst) begin
      m_busy = 0; m_squash = 1'b0; m_turn_st = 1'b1;
    end else if (m_busy == 0) begin
      st_ok = st_write;
      ld_ok = ld_read && !flush;
      if (st_ok && (!ld_ok || m_turn_st)) begin
        m_busy = 2; m_addr = st_address; m_wdata = st_wdata; m_be = st_byte_enable;
        m_turn_st = 1'b0;
      end else if (ld_ok) begin
        m_busy = 1; m_addr = ld_address & 32'hFFFF_FFFC; m_wdata = '0; m_be = 4'hF;
        m_turn_st = 1'b1;
      end
    end else if (dc_resp) begin
      m_busy = 0; m_squash = 1'b0;
    end else if (m_busy == 1 && flush) begin
      m_squash = 1'b1;
    end
    #1;
  endtask

  task automatic cyc_neg();
    bit act, e_rd, e_wr, e_ld, e_st;
    @(negedge clk);
    act  = !rst && m_busy != 0;
    e_rd = !rst && m_busy == 1;
    e_wr = !rst && m_busy == 2;
    e_ld = e_rd && dc_resp && !m_squash && !flush;
    e_st = e_wr && dc_resp;
    chk("ctl", 32'({dc_read, dc_write, ld_resp, st_resp}), 32'({e_rd, e_wr, e_ld, e_st}));
    chk("dc_address", dc_address, act ? m_addr : 32'h0);
    chk("dc_wdata", dc_wdata, act ? m_wdata : 32'h0);
    chk("dc_byte_enable", 32'(dc_byte_enable), act ? 32'(m_be) : 32'h0);
    chk("ld_rdata", ld_rdata, e_ld ? dc_rdata : 32'h0);
  endtask

  typedef struct {
    bit          is_st;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          dly;
    logic [31:0] rdata;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_be;
  } vec_t;

  vec_t vecs[6];
  int   order[$];

  task automatic apply_vec(input vec_t v);
    bit got = 1'b0;
    delay_cfg = v.dly;
    fixed_rdata = v.rdata;
    cyc_start();
    if (v.is_st) begin
      st_write = 1'b1; st_address = v.addr; st_wdata = v.wdata; st_byte_enable = v.be;
    end else begin
      ld_read = 1'b1; ld_address = v.addr;
    end
    cyc_neg();
    chk("vec_idle", 32'({dc_read, dc_write}), 32'h0);
    for (int i = 1; i <= 12 && !got; i++) begin
      cyc_start();
      cyc_neg();
      if (i == 1) begin
        chk("vec_ctl", 32'({dc_read, dc_write}), v.is_st ? 32'h1 : 32'h2);
        chk("vec_addr", dc_address, v.exp_addr);
        chk("vec_wdata", dc_wdata, v.exp_wdata);
        chk("vec_be", 32'(dc_byte_enable), 32'(v.exp_be));
      end
      if (ld_resp || st_resp) begin
        got = 1'b1;
        chk("vec_latency", 32'(i), 32'(v.dly + 1));
        chk("vec_owner", 32'({ld_resp, st_resp}), v.is_st ? 32'h1 : 32'h2);
        if (!v.is_st) chk("vec_rdata", ld_rdata, v.rdata);
      end
    end
    if (!got) chk("vec_timeout", 32'h0, 32'h1);
    cyc_start();
    st_write = 1'b0; ld_read = 1'b0;
    cyc_neg();
    chk("vec_back_idle", 32'({dc_read, dc_write}), 32'h0);
  endtask

  // Records the kind (1 load, 2 store) of each new cache transaction.
  task automatic collect(input int n, input bit reissue_st);
    bit s, l;
    bit reissue = 1'b0, reissued = 1'b0;
    logic [1:0] a, prev = 2'b00;
    order.delete();
    for (int i = 0; i < 60 && order.size() < n; i++) begin
      s = st_resp; l = ld_resp;
      cyc_start();
      flush = 1'b0;
      if (reissue) begin
        st_write = 1'b1; st_address = 32'h504; st_wdata = 32'h3333_4444; st_byte_enable = 4'hF;
        reissue = 1'b0;
      end
      if (s) begin
        st_write = 1'b0;
        if (reissue_st && !reissued) begin reissue = 1'b1; reissued = 1'b1; end
      end
      if (l) ld_read = 1'b0;
      cyc_neg();
      a = {dc_read, dc_write};
      if (a != 2'b00 && prev == 2'b00) order.push_back(dc_write ? 2 : 1);
      prev = a;
    end
  endtask

  task automatic drain(input int budget);
    bit s, l, done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      s = st_resp; l = ld_resp;
      cyc_start();
      if (s) st_write = 1'b0;
      if (l) ld_read = 1'b0;
      cyc_neg();
      done = !st_write && !ld_read && !dc_read && !dc_write;
    end
    if (!done) chk("drain_timeout", 32'h0, 32'h1);
  endtask

  initial begin
    bit s, l, got;
    int exp_ord[3];

    vecs = '{
      '{1'b1, 32'h100,       32'hDEAD_BEEF, 4'hF,    3, 32'h0,         32'h100,       32'hDEAD_BEEF, 4'hF},
      '{1'b0, 32'h206,       32'h0,         4'h0,    1, 32'h1234_5678, 32'h204,       32'h0,         4'hF},
      '{1'b1, 32'h3C,        32'h0000_AB00, 4'b0010, 0, 32'h0,         32'h3C,        32'h0000_AB00, 4'b0010},
      '{1'b0, 32'hFFFF_FFFF, 32'h0,         4'h0,    2, 32'hA5A5_5A5A, 32'hFFFF_FFFC, 32'h0,         4'hF},
      '{1'b0, 32'h0,         32'h0,         4'h0,    0, 32'h0,         32'h0,         32'h0,         4'hF},
      '{1'b1, 32'hFFFF_FFFC, 32'h1122_3344, 4'b1100, 5, 32'h0,         32'hFFFF_FFFC, 32'h1122_3344, 4'b1100}
    };

    // Reset state
    for (int i = 0; i < 3; i++) begin
      cyc_start();
      cyc_neg();
      chk("reset_ctl", 32'({dc_read, dc_write, ld_resp, st_resp}), 32'h0);
      chk("reset_addr", dc_address, 32'h0);
    end
    cyc_start(); rst = 1'b0; cyc_neg();

    // Lone requests
    foreach (vecs[i]) apply_vec(vecs[i]);

    // Contention right after reset: store, load, store
    cyc_start(); rst = 1'b1; cyc_neg();
    cyc_start(); rst = 1'b0; cyc_neg();
    delay_cfg = 1;
    cyc_start();
    st_write = 1'b1; st_address = 32'h500; st_wdata = 32'h1111_2222; st_byte_enable = 4'hF;
    ld_read = 1'b1; ld_address = 32'h600;
    cyc_neg();
    collect(3, 1'b1);
    exp_ord = '{2, 1, 2};
    chk("cont_count", 32'(order.size()), 32'h3);
    for (int i = 0; i < 3 && i < order.size(); i++) chk("cont_order", 32'(order[i]), 32'(exp_ord[i]));
    drain(30);

    // Flush in IDLE with both pending: store first, then the load
    cyc_start();
    st_write = 1'b1; st_address = 32'h700; st_wdata = 32'hAAAA_5555; st_byte_enable = 4'b0101;
    ld_read = 1'b1; ld_address = 32'h800; flush = 1'b1;
    cyc_neg();
    collect(2, 1'b0);
    chk("fidle_count", 32'(order.size()), 32'h2);
    if (order.size() >= 2) begin
      chk("fidle_first", 32'(order[0]), 32'h2);
      chk("fidle_second", 32'(order[1]), 32'h1);
    end
    drain(30);

    // Flush mid-load: cache access completes, load response squashed
    delay_cfg = 2; fixed_rdata = 32'hCAFE_F00D;
    cyc_start(); ld_read = 1'b1; ld_address = 32'h40; cyc_neg();
    cyc_start(); flush = 1'b1; cyc_neg();
    chk("fml_read", 32'(dc_read), 32'h1);
    cyc_start(); flush = 1'b0; cyc_neg();
    cyc_start(); cyc_neg();
    chk("fml_read_held", 32'(dc_read), 32'h1);
    chk("fml_ld_resp", 32'(ld_resp), 32'h0);
    cyc_start(); ld_address = 32'h84; cyc_neg();
    chk("fml_idle", 32'({dc_read, dc_write}), 32'h0);
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      cyc_start(); cyc_neg();
      if (i == 0) chk("fml_new_addr", dc_address, 32'h84);
      if (ld_resp) begin
        got = 1'b1;
        chk("fml_new_rdata", ld_rdata, 32'hCAFE_F00D);
      end
    end
    if (!got) chk("fml_new_timeout", 32'h0, 32'h1);
    cyc_start(); ld_read = 1'b0; cyc_neg();

    // Reset during STORE, then a late dc_resp
    delay_cfg = 10;
    cyc_start();
    st_write = 1'b1; st_address = 32'h900; st_wdata = 32'h5A5A_0F0F; st_byte_enable = 4'hF;
    cyc_neg();
    cyc_start(); cyc_neg();
    chk("rst_pre_write", 32'(dc_write), 32'h1);
    cyc_start(); rst = 1'b1; st_write = 1'b0; cyc_neg();
    chk("rst_ctl", 32'({dc_read, dc_write, ld_resp, st_resp}), 32'h0);
    chk("rst_addr", dc_address, 32'h0);
    cyc_start(); rst = 1'b0; late_req++; cyc_neg();
    chk("rst_late_st_resp", 32'(st_resp), 32'h0);
    for (int i = 0; i < 3; i++) begin
      cyc_start(); cyc_neg();
      chk("rst_after", 32'({dc_write, st_resp}), 32'h0);
    end

    // Randomized traffic against the model
    rand_mode = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      s = st_resp; l = ld_resp;
      cyc_start();
      rst   = ($urandom_range(0, 199) == 0);
      flush = ($urandom_range(0, 9) == 0);
      if (s || rst) st_write = 1'b0;
      else if (!st_write && $urandom_range(0, 3) == 0) begin
        st_write = 1'b1; st_address = $urandom & 32'hFFFF_FFFC;
        st_wdata = $urandom; st_byte_enable = 4'($urandom);
      end
      if (l || rst || (flush && $urandom_range(0, 1) == 1)) ld_read = 1'b0;
      else if (!ld_read && $urandom_range(0, 2) == 0) begin
        ld_read = 1'b1; ld_address = $urandom;
      end
      cyc_neg();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dcache_port_arbiter.md
Name: dcache_port_arbiter

Overview:
- Single-port responder that sits between two requesters and the data cache.
- Requester 1 is the ROB store-commit port: it asserts write, address, wdata and byte enable, holds them until resp, then drops them.
- Requester 2 is the load/store buffer load port: it asserts read and address, holds them until resp.
- The block arbitrates the two requesters round-robin, registers the granted request onto the cache port, and routes the cache response back to the owner. A flush squashes in-flight loads without aborting the cache transaction.

Parameters:
- XLEN, 32, data/address width.
- STORE_FIRST, 1, value of the priority bit after reset (1 = the store port wins the first tie).

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- flush  in  1  ROB mispredict flush; squashes load traffic
- st_write  in  1  store request, held until st_resp
- st_address  in  XLEN  word-aligned store address
- st_wdata  in  XLEN  lane-shifted store data
- st_byte_enable  in  4  store byte mask
- st_resp  out  1  store complete, one cycle
- ld_read  in  1  load request, held until ld_resp
- ld_address  in  XLEN  load byte address
- ld_rdata  out  XLEN  raw cache word
- ld_resp  out  1  load complete, one cycle
- dc_read  out  1  cache read
- dc_write  out  1  cache write
- dc_address  out  XLEN  cache address
- dc_wdata  out  XLEN  cache write data
- dc_byte_enable  out  4  cache byte mask
- dc_rdata  in  XLEN  cache read data
- dc_resp  in  1  cache done, one cycle

Behaviour:
- State machine has three states: IDLE, LOAD, STORE. The priority bit pri_store and the squash flag drop are registered.
- Reset values:
  - state = IDLE, pri_store = STORE_FIRST, drop = 0.
  - All outputs are 0 in reset and in IDLE.
- IDLE arbitration:
  - Store eligible = st_write.
  - Load eligible = ld_read & ~flush.
  - Only one eligible: grant it.
  - Both eligible: grant the store if pri_store = 1, else grant the load.
  - On a grant, capture the request into internal registers and go to STORE or LOAD at the next edge.
  - pri_store toggles to favour the other port after each grant.
- Captured load request:
  - dc_address = {ld_address[XLEN-1:2], 2'b00}.
  - dc_byte_enable = 4'b1111, dc_wdata = 0.
- Captured store request:
  - dc_address = st_address, dc_wdata = st_wdata, dc_byte_enable = st_byte_enable.
  - No lane shifting is done here.
- LOAD and STORE states:
  - dc_read (LOAD) or dc_write (STORE) held at 1, with dc_address, dc_wdata and dc_byte_enable stable from the captured registers until dc_resp.
- Response routing:
  - In the dc_resp cycle, combinationally assert ld_resp with ld_rdata = dc_rdata (LOAD, drop = 0), or assert st_resp (STORE).
  - ld_rdata = 0 whenever ld_resp = 0.
  - The state returns to IDLE at that edge.
- Latency:
  - Request seen in IDLE at cycle N → dc_read/dc_write high at N+1.
  - Requester resp in the same cycle as dc_resp.
  - Next grant no earlier than the cycle after dc_resp.
- Flush handling:
  - Flush in LOAD (any cycle, including the dc_resp cycle): set drop, or suppress ld_resp in that same cycle.
  - The cache transaction runs to completion. When dc_resp arrives: ld_resp = 0, drop clears, return to IDLE.
  - Flush in IDLE: loads are not granted that cycle; a pending store is still granted.
  - Flush never affects STORE. A committed store always completes and raises st_resp.
- Protocol assumptions and checks:
  - dc_resp is ignored while in IDLE.
  - Requesters drop their request the cycle after resp. A still-high request in IDLE is treated as a new request.
  - Request signal changes while in LOAD/STORE are ignored, since the captured copy drives the cache.
- Reset mid-transaction: return to IDLE immediately, drop all outputs, no resp is generated, and a late dc_resp is ignored.

Test Plan:
- Lone store: st_write=1, addr 0x100, wdata 0xDEADBEEF, be 4'b1111; dc_resp after 3 cycles.
  - Required: dc_write=1 from N+1, with addr 0x100 and wdata 0xDEADBEEF.
  - Required: st_resp=1 exactly in the dc_resp cycle, then IDLE.
- Lone load: ld_read=1, addr 0x206; dc_rdata 0x12345678 with dc_resp.
  - Required: dc_address=0x204, be=1111, dc_read=1.
  - Required: ld_resp=1 and ld_rdata=0x12345678 in that cycle.
- Contention: both ports assert together after reset (STORE_FIRST=1), each request held until its own resp.
  - Required grant order: store, then load, then store.
  - Required: each dc_* transaction stays stable throughout; no overlap between transactions.
- Flush mid-load: flush pulsed 1 cycle while in LOAD, dc_resp 2 cycles later.
  - Required: dc_read held until dc_resp, ld_resp stays 0, arbiter back in IDLE.
  - Required: a new load the following cycle is served normally.
- Flush in IDLE with both pending: load not granted, store granted; afterwards the load is served once flush is low.
- Reset during STORE with dc_resp arriving 1 cycle after reset: all outputs 0, st_resp never asserted, state IDLE.
